// File: rtl/pit_table.sv
// Pending Interest Table: holds outstanding interests (prefix, length, face mask),
// matches FIB data prefixes against them and forwards the payload to the waiting faces.
module pit_table #(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned DATA_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_valid,
  input  logic [63:0] int_prefix,
  input  logic [5:0]  int_len,
  input  logic [1:0]  int_face,
  output logic        int_ready,
  output logic        int_drop,
  input  logic        prefix_ready,
  input  logic [63:0] fib_prefix,
  input  logic [5:0]  fib_len,
  input  logic [7:0]  fib_data,
  output logic        rejected,
  output logic        start_send_to_pit,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic [3:0]  out_face_mask,
  output logic        out_last,
  output logic [4:0]  entry_count
);

  localparam int unsigned IW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [9:0]  LAST = 10'(DATA_BYTES - 1);

  typedef enum logic [1:0] {IDLE, MATCH, RESP, XFER} state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid;
  logic [63:0]        prefix [ENTRIES];
  logic [5:0]         len    [ENTRIES];
  logic [3:0]         mask   [ENTRIES];

  logic [63:0] lk_prefix;
  logic [5:0]  lk_len;
  logic        hit;
  logic [IW-1:0] hit_idx;
  logic [9:0]  cnt;

  logic          dup_hit, free_hit, m_hit;
  logic [IW-1:0] dup_idx, free_idx, m_idx;
  logic          ins_fire;
  logic [3:0]    face_bit;

  assign int_ready = rst && (state == IDLE) && !prefix_ready;
  assign ins_fire  = int_valid && int_ready;
  assign face_bit  = 4'b0001 << int_face;

  // Lowest-index search for duplicate, free slot and lookup match.
  always_comb begin
    dup_hit  = 1'b0;
    dup_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    m_hit    = 1'b0;
    m_idx    = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!dup_hit && valid[i] && prefix[i] == int_prefix && len[i] == int_len) begin
        dup_hit = 1'b1;
        dup_idx = IW'(i);
      end
      if (!free_hit && !valid[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
      if (!m_hit && valid[i] && prefix[i] == lk_prefix && len[i] == lk_len) begin
        m_hit = 1'b1;
        m_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (prefix_ready) state_nxt = MATCH;
      MATCH:   state_nxt = RESP;
      RESP:    state_nxt = hit ? XFER : IDLE;
      XFER:    if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Entry payload needs no reset: it is only ever read through a set valid bit.
  always_ff @(posedge clk) begin
    if (ins_fire) begin
      if (dup_hit) begin
        mask[dup_idx] <= mask[dup_idx] | face_bit;
      end else if (free_hit) begin
        prefix[free_idx] <= int_prefix;
        len[free_idx]    <= int_len;
        mask[free_idx]   <= face_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      valid             <= '0;
      entry_count       <= '0;
      lk_prefix         <= '0;
      lk_len            <= '0;
      hit               <= 1'b0;
      hit_idx           <= '0;
      cnt               <= '0;
      int_drop          <= 1'b0;
      rejected          <= 1'b0;
      start_send_to_pit <= 1'b0;
      out_valid         <= 1'b0;
      out_byte          <= '0;
      out_face_mask     <= '0;
      out_last          <= 1'b0;
    end else begin
      state             <= state_nxt;
      int_drop          <= 1'b0;
      rejected          <= 1'b0;
      start_send_to_pit <= 1'b0;
      out_valid         <= 1'b0;
      out_byte          <= '0;
      out_face_mask     <= '0;
      out_last          <= 1'b0;

      if (ins_fire && !dup_hit) begin
        if (free_hit) begin
          valid[free_idx] <= 1'b1;
          entry_count     <= entry_count + 5'd1;
        end else begin
          int_drop <= 1'b1;
        end
      end

      // Response pulses are registered on the MATCH edge so they are high exactly while in RESP.
      unique case (state)
        IDLE: begin
          if (prefix_ready) begin
            lk_prefix <= fib_prefix;
            lk_len    <= fib_len;
          end
        end
        MATCH: begin
          hit               <= m_hit;
          hit_idx           <= m_idx;
          rejected          <= !m_hit;
          start_send_to_pit <= m_hit;
        end
        XFER: begin
          out_valid     <= 1'b1;
          out_byte      <= fib_data;
          out_face_mask <= mask[hit_idx];
          out_last      <= (cnt == LAST);
          if (cnt == LAST) begin
            cnt            <= '0;
            valid[hit_idx] <= 1'b0;
            entry_count    <= entry_count - 5'd1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table: transaction-level table model plus directed and random stimulus.
module tb_pit_table;
  localparam int NE = 16;
  localparam int DB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_valid = 1'b0;
  logic [63:0] int_prefix = '0;
  logic [5:0]  int_len = '0;
  logic [1:0]  int_face = '0;
  logic        int_ready, int_drop;
  logic        prefix_ready = 1'b0;
  logic [63:0] fib_prefix = '0;
  logic [5:0]  fib_len = '0;
  logic [7:0]  fib_data = '0;
  logic        rejected, start_send_to_pit, out_valid, out_last;
  logic [7:0]  out_byte;
  logic [3:0]  out_face_mask;
  logic [4:0]  entry_count;

  pit_table #(.ENTRIES(NE), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_prefix(int_prefix), .int_len(int_len), .int_face(int_face),
    .int_ready(int_ready), .int_drop(int_drop),
    .prefix_ready(prefix_ready), .fib_prefix(fib_prefix), .fib_len(fib_len), .fib_data(fib_data),
    .rejected(rejected), .start_send_to_pit(start_send_to_pit),
    .out_valid(out_valid), .out_byte(out_byte), .out_face_mask(out_face_mask),
    .out_last(out_last), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: table contents plus a timeline counter m_t = edges since the lookup was accepted.
  bit          m_valid [NE];
  logic [63:0] m_pfx   [NE];
  logic [5:0]  m_len   [NE];
  logic [3:0]  m_mask  [NE];
  int          m_t = -1;
  int          m_hidx = -1;
  bit          m_hit;
  logic [63:0] m_lp;
  logic [5:0]  m_ll;
  bit          e_drop, e_rej, e_start, e_ov, e_last;
  logic [7:0]  e_byte = '0;
  logic [3:0]  e_mask = '0;
  int          md, mf;

  function automatic int find(input logic [63:0] p, input logic [5:0] l);
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_pfx[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NE; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      m_t = -1;
      e_drop = 0; e_rej = 0; e_start = 0; e_ov = 0; e_last = 0;
      e_byte = '0; e_mask = '0;
    end else begin
      e_drop = 0; e_rej = 0; e_start = 0; e_ov = 0; e_last = 0;
      e_byte = '0; e_mask = '0;
      if (m_t < 0) begin
        if (prefix_ready) begin
          m_lp = fib_prefix; m_ll = fib_len; m_t = 0;
        end else if (int_valid) begin
          md = find(int_prefix, int_len);
          if (md >= 0) begin
            m_mask[md] = m_mask[md] | (4'b0001 << int_face);
          end else begin
            mf = -1;
            for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) mf = i;
            if (mf < 0) e_drop = 1;
            else begin
              m_valid[mf] = 1'b1; m_pfx[mf] = int_prefix; m_len[mf] = int_len;
              m_mask[mf] = 4'b0001 << int_face;
            end
          end
        end
      end else begin
        m_t++;
        if (m_t == 1) begin
          m_hidx = find(m_lp, m_ll);
          m_hit = (m_hidx >= 0);
          e_rej = !m_hit; e_start = m_hit;
        end else if (!m_hit) begin
          m_t = -1;
        end else if (m_t >= 3) begin
          e_ov = 1; e_byte = fib_data; e_mask = m_mask[m_hidx];
          e_last = (m_t - 3 == DB - 1);
          if (e_last) begin
            m_valid[m_hidx] = 1'b0;
            m_t = -1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("int_ready", int_ready, rst && m_t < 0 && !prefix_ready);
    check("int_drop", int_drop, e_drop);
    check("rejected", rejected, e_rej);
    check("start_send", start_send_to_pit, e_start);
    check("out_valid", out_valid, e_ov);
    check("entry_count", entry_count, m_count());
    if (e_ov || !rst) begin
      check("out_byte", out_byte, e_byte);
      check("out_face_mask", out_face_mask, e_mask);
      check("out_last", out_last, e_last);
    end
  end

  // FIB payload source: byte index in sequence mode, random otherwise.
  bit seq_mode = 0;
  always @(negedge clk) begin
    #1;
    fib_data = (seq_mode && m_t >= 2) ? 8'(m_t - 2) : 8'($urandom);
  end

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (m_t < 0) return;
      @(negedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_idle: table still busy after 3000 cycles");
  endtask

  task automatic insert(input logic [63:0] p, input logic [5:0] l, input logic [1:0] f, output logic dr);
    int_prefix = p; int_len = l; int_face = f; int_valid = 1'b1; dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (int_ready) begin
        @(negedge clk); dr = int_drop; #1;
        int_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    int_valid = 1'b0;
    n_checks++; n_fail++;
    $display("FAIL insert_timeout: int_ready never high");
  endtask

  task automatic lookup(input logic [63:0] p, input logic [5:0] l, output int d, output logic h);
    wait_idle();
    fib_prefix = p; fib_len = l; prefix_ready = 1'b1;
    d = 0; h = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if ((rejected || start_send_to_pit) && d == 0) begin d = i; h = start_send_to_pit; end
      if (i == 1) begin #1; prefix_ready = 1'b0; end
    end
    #1;
  endtask

  task automatic xfer_mon(output int n, output logic [3:0] msk, output int lastpos,
                          output int seqerr, output logic [7:0] lastb);
    n = 0; msk = '0; lastpos = -1; seqerr = 0; lastb = '0;
    for (int i = 0; i < DB + 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n == 0) msk = out_face_mask;
        if (out_byte !== 8'(n)) seqerr++;
        if (out_last) begin
          lastpos = n; lastb = out_byte; n++;
          break;
        end
        n++;
      end
    end
    #1;
  endtask

  logic [63:0] pool [20];
  logic [5:0]  plen [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n, lp, se, k, idx;
    logic h, dr;
    logic [3:0] msk;
    logic [7:0] lb;

    repeat (3) @(negedge clk);
    check("rst_int_ready", int_ready, 0);
    check("rst_entry_count", entry_count, 0);
    check("rst_out_valid", out_valid, 0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // lookup on empty table
    lookup(64'h1234, 6'd8, d, h);
    check("miss_latency", d, 2);
    check("miss_rejected", h, 0);
    wait_idle();
    check("miss_count", entry_count, 0);

    // single interest, sequential payload
    insert(64'hA5A5_0000_0000_0001, 6'd16, 2'd2, dr);
    check("ins1_drop", dr, 0);
    check("ins1_count", entry_count, 1);
    seq_mode = 1;
    lookup(64'hA5A5_0000_0000_0001, 6'd16, d, h);
    check("hit1_latency", d, 2);
    check("hit1_start", h, 1);
    xfer_mon(n, msk, lp, se, lb);
    seq_mode = 0;
    check("x1_bytes", n, 1024);
    check("x1_mask", msk, 4'b0100);
    check("x1_lastpos", lp, 1023);
    check("x1_lastbyte", lb, 8'hFF);
    check("x1_seq_errors", se, 0);
    check("x1_count_after", entry_count, 0);

    // aggregation from faces 0 and 3
    insert(64'hC0DE_0000_0000_00AA, 6'd32, 2'd0, dr);
    insert(64'hC0DE_0000_0000_00AA, 6'd32, 2'd3, dr);
    check("agg_count", entry_count, 1);
    lookup(64'hC0DE_0000_0000_00AA, 6'd32, d, h);
    check("agg_start", h, 1);
    xfer_mon(n, msk, lp, se, lb);
    check("agg_mask", msk, 4'b1001);
    check("agg_bytes", n, 1024);

    // fill table, overflow, aggregate into a full table
    for (int i = 0; i < 16; i++) insert(64'hBEEF_0000_0000_0000 + 64'(i), 6'd20, 2'(i), dr);
    check("full_count", entry_count, 16);
    insert(64'hBEEF_0000_0000_0100, 6'd20, 2'd0, dr);
    check("overflow_drop", dr, 1);
    check("overflow_count", entry_count, 16);
    insert(64'hBEEF_0000_0000_0005, 6'd20, 2'd3, dr);
    check("dup_full_drop", dr, 0);
    check("dup_full_count", entry_count, 16);
    lookup(64'hBEEF_0000_0000_0005, 6'd20, d, h);
    xfer_mon(n, msk, lp, se, lb);
    check("dup_full_mask", msk, 4'b1010);
    check("dup_full_after", entry_count, 15);

    // lookup wins over a simultaneous insert
    wait_idle();
    int_prefix = 64'hFACE_0000_0000_0001; int_len = 6'd12; int_face = 2'd1; int_valid = 1'b1;
    fib_prefix = 64'hDEAD_0000_0000_0000; fib_len = 6'd12; prefix_ready = 1'b1;
    @(negedge clk);
    check("prio_count_held", entry_count, 15);
    check("prio_not_ready", int_ready, 0);
    #1 prefix_ready = 1'b0;
    insert(64'hFACE_0000_0000_0001, 6'd12, 2'd1, dr);
    check("prio_insert_later", entry_count, 16);

    // reset in the middle of a transfer
    lookup(64'hBEEF_0000_0000_0006, 6'd20, d, h);
    check("abort_start", h, 1);
    k = 0;
    for (int i = 0; i < DB && k <= 500; i++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_last", out_last, 0);
    check("abort_count", entry_count, 0);
    #1;
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    lookup(64'hBEEF_0000_0000_0006, 6'd20, d, h);
    check("post_rst_latency", d, 2);
    check("post_rst_reject", h, 0);

    // random traffic
    for (int i = 0; i < 20; i++) begin
      pool[i] = {32'($urandom), 32'($urandom)};
      plen[i] = 6'($urandom);
    end
    pool[19] = pool[0];
    plen[19] = plen[0] ^ 6'd1;
    for (int c = 0; c < 8000; c++) begin
      int_valid = ($urandom % 3 == 0);
      idx = $urandom % 20;
      int_prefix = pool[idx]; int_len = plen[idx]; int_face = 2'($urandom);
      prefix_ready = ($urandom % 12 == 0);
      idx = $urandom % 24;
      fib_prefix = (idx < 20) ? pool[idx] : {32'($urandom), 32'($urandom)};
      fib_len = (idx < 20) ? plen[idx] : 6'($urandom);
      @(negedge clk); #1;
    end
    int_valid = 1'b0;
    prefix_ready = 1'b0;
    wait_idle();
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pit_table.md
PIT_TABLE -- requirements
Module: pit_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of pending-interest entries.
REQ-002 SHALL have parameter DATA_BYTES, default 1024, meaning the fixed payload length of a data packet in bytes.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 int_valid  in  1  interest insert request from the face side.
REQ-006 int_prefix  in  64  interest name prefix.
REQ-007 int_len  in  6  interest prefix length.
REQ-008 int_face  in  2  index of the face the interest arrived on.
REQ-009 int_ready  out  1  insert accepted this cycle when high together with int_valid.
REQ-010 int_drop  out  1  one-cycle pulse: interest discarded because the table is full.
REQ-011 prefix_ready  in  1  FIB data-prefix lookup request.
REQ-012 fib_prefix  in  64  data prefix from FIB.
REQ-013 fib_len  in  6  data prefix length from FIB.
REQ-014 fib_data  in  8  payload byte stream from FIB.
REQ-015 rejected  out  1  one-cycle pulse: no pending interest for the data.
REQ-016 start_send_to_pit  out  1  one-cycle pulse: match found, FIB shall begin streaming.
REQ-017 out_valid  out  1  out_byte and out_face_mask are valid.
REQ-018 out_byte  out  8  forwarded payload byte.
REQ-019 out_face_mask  out  4  faces the byte is to be sent to (bit n = face n).
REQ-020 out_last  out  1  marks the final payload byte.
REQ-021 entry_count  out  5  number of valid entries.

Function
REQ-022 Each entry SHALL hold valid, prefix[63:0], len[5:0], face_mask[3:0].
REQ-023 FSM states SHALL be IDLE, MATCH, RESP, XFER; only IDLE accepts new requests.
REQ-024 int_ready SHALL equal (state==IDLE && !prefix_ready); a lookup request has priority over an insert in the same cycle.
REQ-025 On an accepted insert, if a valid entry has equal prefix and len, it SHALL OR bit int_face into that entry's face_mask (aggregation, count unchanged).
REQ-026 Otherwise the insert SHALL fill the lowest-index invalid entry with face_mask = 1<<int_face and increment entry_count.
REQ-027 Otherwise (table full, no duplicate) the interest SHALL be dropped, with int_drop high in the cycle after acceptance and the table unchanged.
REQ-028 In IDLE with prefix_ready high, fib_prefix/fib_len SHALL be latched and the next state SHALL be MATCH.
REQ-029 MATCH SHALL compare all entries in parallel, requiring an exact match of all 64 prefix bits and len with valid=1.
REQ-030 MATCH SHALL register hit and the lowest matching index, then go to RESP.
REQ-031 RESP on miss SHALL drive rejected=1 for one cycle and go to IDLE.
REQ-032 RESP on hit SHALL drive start_send_to_pit=1 for one cycle and go to XFER.
REQ-033 Response latency: prefix_ready sampled at edge N SHALL give rejected/start_send_to_pit high during cycle N+2.
REQ-034 XFER SHALL run a 10-bit byte counter from 0 and sample fib_data on each of DATA_BYTES consecutive edges, starting with the first edge in XFER.
REQ-035 Each sampled byte SHALL appear on out_byte with out_valid=1 in the following cycle.
REQ-036 out_face_mask SHALL equal the hit entry's mask for the whole transfer.
REQ-037 out_last SHALL be high with the byte sampled at count DATA_BYTES-1.
REQ-038 At count DATA_BYTES-1 the hit entry SHALL be invalidated, entry_count decremented, and the next state SHALL be IDLE.
REQ-039 Inserts and lookups arriving outside IDLE SHALL be ignored (int_ready=0); the source holds its request.
REQ-040 All pulse outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-041 While rst=0, all entries SHALL be invalidated, state=IDLE, counter=0, and every output driven 0 except int_ready, which shall be 0.
REQ-042 Reset asserted mid-XFER SHALL abort the transfer immediately with no out_last, and the table SHALL be empty after release.
REQ-043 The first edge after rst rises SHALL behave as IDLE with an empty table.

Verification
REQ-044 Insert prefix 0xA5A5_0000_0000_0001, len 16, face 2; lookup same -> start_send_to_pit at N+2; fib_data=count[7:0] -> 1024 bytes 0x00..0xFF repeating, out_face_mask=0100, out_last on byte 1023, entry_count 1->0.
REQ-045 Lookup prefix 0x1234, len 8 on an empty table -> rejected pulse at N+2, no out_valid, entry_count stays 0.
REQ-046 Insert the same prefix/len from faces 0 and 3 -> entry_count=1; matched transfer shows out_face_mask=1001.
REQ-047 Insert 16 distinct prefixes, then a 17th distinct prefix -> int_drop pulse, entry_count=16; a duplicate of entry 5 is still aggregated.
REQ-048 int_valid and prefix_ready high in the same IDLE cycle -> lookup proceeds and the insert is accepted only after returning to IDLE.
REQ-049 rst=0 at byte 500 of a transfer -> all outputs 0 and entry_count=0; a lookup after release -> rejected.
